ysyx_25040129_rd_arbiter: RTL and testbench
===========================================

# ysyx_25040129_rd_arbiter

Two-master, one-slave AXI4-Lite read-channel arbiter sitting between the instruction fetch unit and load/store unit on one side and the shared memory read port on the other. It grants one outstanding read at a time, routes address and data, and prevents starvation with round-robin tie-breaking. An optional watchdog returns a synthetic SLVERR when the slave stops responding.

## Interface
- `TIMEOUT_CYCLES`, default 64: watchdog limit in cycles per AR or R phase; valid range 1..65535. It is used only when `RD_ARB_TIMEOUT_EN` is defined.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `ifu_araddr` in 32: IFU read address.
- `ifu_arvalid` in 1: IFU address valid.
- `ifu_arready` out 1: IFU address accepted.
- `ifu_rdata` out 32: read data, broadcast.
- `ifu_rresp` out 2: read response, broadcast.
- `ifu_rvalid` out 1: IFU data valid; gated by grant.
- `ifu_rready` in 1: IFU data ready.
- `lsu_araddr` in 32, `lsu_arvalid` in 1, `lsu_arready` out 1: LSU read address channel.
- `lsu_rdata` out 32, `lsu_rresp` out 2, `lsu_rvalid` out 1, `lsu_rready` in 1: LSU read data channel.
- `s_araddr` out 32, `s_arvalid` out 1, `s_arready` in 1: slave read address channel.
- `s_rdata` in 32, `s_rresp` in 2, `s_rvalid` in 1, `s_rready` out 1: slave read data channel.

## Operation
- Registered state: `state` (IDLE, AR, R, plus ERR with the macro), `owner` (0 = IFU, 1 = LSU), `last_owner`.
- **IDLE**
  - All valids and readies toward masters and slave are 0.
  - If exactly one `*_arvalid` is high, grant that master.
  - If both are high, grant the master that is not `last_owner`.
  - On a grant, latch `owner` and go to AR.
- **AR**
  - `s_araddr` is the owner's araddr (combinational mux). `s_arvalid` is the owner's arvalid.
  - The owner's arready equals `s_arready`. The non-owner's arready is 0.
  - On `s_arvalid && s_arready`, go to R.
- **R**
  - `s_rready` equals the owner's rready. The owner's rvalid equals `s_rvalid`. The non-owner's rvalid is 0.
  - On `s_rvalid && s_rready`, set `last_owner <= owner` and go to IDLE.
- `s_rdata` and `s_rresp` drive both masters' rdata/rresp in every state except ERR. Masters qualify the data with their own rvalid.
- Masters hold araddr stable while arvalid is high (AXI rule). Behaviour on an arvalid withdrawn before its handshake is unspecified.
- A stale slave response arriving after reset or after a timeout is out of scope.

## Timing
- Reset values:
  - `state` = IDLE, `owner` = 0, `last_owner` = 1, so IFU wins the first tie.
  - All `*_arready`, `*_rvalid`, `s_arvalid`, `s_rready` are 0.
- Grant latency:
  - Master arvalid is sampled high at edge N; `s_arvalid` is high in cycle N+1.
  - If `s_arready` is already 1, the address handshake completes in N+1 and R starts in N+2.
- R handshake in cycle M leads to IDLE in M+1. The earliest next `s_arvalid` is M+2, so there is at least one IDLE cycle between transactions.
- Data path R to master is combinational, with zero added latency in R.
- Continuous contention: grants alternate IFU, LSU, IFU, and so on.
- Reset in any state: IDLE on the next cycle with the reset values above.

## Configuration
- `RD_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on every entry to AR and R and increments each cycle the phase handshake does not occur.
  - When the counter equals `TIMEOUT_CYCLES-1` and there is no handshake that cycle, go to ERR.
  - In ERR: owner rvalid = 1, rresp = 2'b10, rdata = 32'h0, `s_arvalid` = 0, `s_rready` = 0.
  - On owner rready, update `last_owner` and go to IDLE.
- Not defined: there is no counter and no ERR state. The arbiter waits indefinitely, and `TIMEOUT_CYCLES` is ignored.

## Test plan
- **Single IFU read:** IFU read of 0x30000000; slave arready = 1, rvalid 2 cycles later with rdata = 0x00000413, rresp = 0 → IFU sees rvalid with 0x00000413; `lsu_rvalid` stays 0; IDLE afterwards.
- **First tie after reset:** IFU (0x30000000) and LSU (0x80000100) arvalid in the same cycle → `s_araddr` = 0x30000000 first, then 0x80000100 after the IFU R handshake.
- **Sustained contention:** both masters request continuously for 6 transactions → grant order IFU, LSU, IFU, LSU, IFU, LSU.
- **Address backpressure:** `s_arready` held low 5 cycles during an LSU read → `s_arvalid` stays high, `s_araddr` stays stable, `lsu_arready` stays 0 until cycle 6.
- **Slave hang, macro on (`TIMEOUT_CYCLES` = 8):** slave never asserts rvalid → owner rvalid with rresp = 2'b10, rdata = 0 after 8 R cycles.
- **Slave hang, macro off:** same stimulus → rvalid stays 0 for 100 cycles.
- **Reset mid-R:** rst asserted in R → the next cycle is IDLE with all valids/readies 0; the next tie grants IFU.

Source files
------------

// File: rtl/ysyx_25040129_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25040129_rd_arbiter
//  Purpose  : Two-master (IFU, LSU) to one-slave AXI4-Lite read-channel
//             arbiter. One outstanding read at a time, round-robin on ties.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    TIMEOUT_CYCLES : watchdog limit per AR or R phase (1..65535), only used
//                     when the RD_ARB_TIMEOUT_EN macro is defined.
//  Build option
//    RD_ARB_TIMEOUT_EN : adds a watchdog and an ERR state that returns a
//                        synthetic SLVERR (rresp 2'b10, rdata 0) to the owner.
//  Ports
//    clk, rst                    : clock, synchronous active-high reset
//    ifu_ar* / ifu_r*            : IFU read address / data channel
//    lsu_ar* / lsu_r*            : LSU read address / data channel
//    s_ar* / s_r*                : shared slave read address / data channel
// ============================================================================
module ysyx_25040129_rd_arbiter #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    // IFU
    input  logic [31:0] ifu_araddr,
    input  logic        ifu_arvalid,
    output logic        ifu_arready,
    output logic [31:0] ifu_rdata,
    output logic [1:0]  ifu_rresp,
    output logic        ifu_rvalid,
    input  logic        ifu_rready,
    // LSU
    input  logic [31:0] lsu_araddr,
    input  logic        lsu_arvalid,
    output logic        lsu_arready,
    output logic [31:0] lsu_rdata,
    output logic [1:0]  lsu_rresp,
    output logic        lsu_rvalid,
    input  logic        lsu_rready,
    // Slave
    output logic [31:0] s_araddr,
    output logic        s_arvalid,
    input  logic        s_arready,
    input  logic [31:0] s_rdata,
    input  logic [1:0]  s_rresp,
    input  logic        s_rvalid,
    output logic        s_rready
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_ar   = 2'd1;
    localparam logic [1:0] c_st_r    = 2'd2;
`ifdef RD_ARB_TIMEOUT_EN
    localparam logic [1:0] c_st_err  = 2'd3;
`endif

    // Out-of-range watchdog limits are rejected at elaboration.
    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be within 1..65535");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [1:0] r_state;
    logic       r_owner;       // 0 = IFU, 1 = LSU
    logic       r_last_owner;  // owner of the last completed read

    logic [1:0] w_state_nxt;
    logic       w_owner_nxt;
    logic       w_last_nxt;

    // ------------------------------------------------------------------------
    // Decode helpers
    // ------------------------------------------------------------------------
    logic w_in_ar;
    logic w_in_r;
    logic w_in_err;
    logic w_any_req;
    logic w_grant_lsu;
    logic w_own_arvalid;
    logic w_own_rready;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_wdt_expire;
    logic w_rvalid_any;
    logic [31:0] w_rdata;
    logic [1:0]  w_rresp;

    assign w_in_ar  = (r_state == c_st_ar);
    assign w_in_r   = (r_state == c_st_r);

    assign w_any_req = ifu_arvalid | lsu_arvalid;
    // A lone request wins outright; on a tie the master that did not own the
    // last completed read wins (last_owner resets to LSU so IFU wins first).
    assign w_grant_lsu = (ifu_arvalid & lsu_arvalid) ? ~r_last_owner : lsu_arvalid;

    assign w_own_arvalid = r_owner ? lsu_arvalid : ifu_arvalid;
    assign w_own_rready  = r_owner ? lsu_rready  : ifu_rready;

    assign w_ar_hs = w_in_ar & w_own_arvalid & s_arready;
    assign w_r_hs  = w_in_r  & s_rvalid & w_own_rready;

    // ------------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------------
`ifdef RD_ARB_TIMEOUT_EN
    localparam logic [15:0] c_wdt_last = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] r_wdt_cnt;

    assign w_in_err = (r_state == c_st_err);

    // Every phase change (including entry to AR and R) restarts the count, so
    // inside AR/R the value is the number of cycles spent without a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdt_cnt <= '0;
        end else if (w_state_nxt != r_state) begin
            r_wdt_cnt <= '0;
        end else begin
            r_wdt_cnt <= r_wdt_cnt + 16'd1;
        end
    end

    assign w_wdt_expire = (r_wdt_cnt == c_wdt_last);
`else
    assign w_in_err     = 1'b0;
    assign w_wdt_expire = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        case (r_state)
            c_st_idle: begin
                if (w_any_req) begin
                    w_state_nxt = c_st_ar;
                    w_owner_nxt = w_grant_lsu;
                end
            end
            c_st_ar: begin
                if (w_ar_hs) begin
                    w_state_nxt = c_st_r;
                end else if (w_wdt_expire) begin
`ifdef RD_ARB_TIMEOUT_EN
                    w_state_nxt = c_st_err;
`endif
                end
            end
            c_st_r: begin
                if (w_r_hs) begin
                    w_state_nxt = c_st_idle;
                    w_last_nxt  = r_owner;
                end else if (w_wdt_expire) begin
`ifdef RD_ARB_TIMEOUT_EN
                    w_state_nxt = c_st_err;
`endif
                end
            end
`ifdef RD_ARB_TIMEOUT_EN
            c_st_err: begin
                // The synthetic SLVERR completes when the owner accepts it.
                if (w_own_rready) begin
                    w_state_nxt = c_st_idle;
                    w_last_nxt  = r_owner;
                end
            end
`endif
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Address channel routing
    // ------------------------------------------------------------------------
    // The address mux runs in every state; it is only qualified by s_arvalid.
    assign s_araddr    = r_owner ? lsu_araddr : ifu_araddr;
    assign s_arvalid   = w_in_ar & w_own_arvalid;
    assign ifu_arready = w_in_ar & ~r_owner & s_arready;
    assign lsu_arready = w_in_ar &  r_owner & s_arready;

    // ------------------------------------------------------------------------
    // Data channel routing
    // ------------------------------------------------------------------------
    assign s_rready     = w_in_r & w_own_rready;
    assign w_rvalid_any = (w_in_r & s_rvalid) | w_in_err;
    assign ifu_rvalid   = w_rvalid_any & ~r_owner;
    assign lsu_rvalid   = w_rvalid_any &  r_owner;

    // Data/response are broadcast; each master qualifies with its own rvalid.
    assign w_rdata = w_in_err ? 32'h0000_0000 : s_rdata;
    assign w_rresp = w_in_err ? 2'b10         : s_rresp;

    assign ifu_rdata = w_rdata;
    assign ifu_rresp = w_rresp;
    assign lsu_rdata = w_rdata;
    assign lsu_rresp = w_rresp;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25040129_rd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_25040129_rd_arbiter
//  Purpose  : Self-checking bench for the IFU/LSU read arbiter. Directed
//             scenarios plus randomized reads, checked against a
//             transaction-level model of the grant rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_25040129_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifu_araddr;
    logic        ifu_arvalid;
    logic        ifu_arready;
    logic [31:0] ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        ifu_rvalid;
    logic        ifu_rready;
    logic [31:0] lsu_araddr;
    logic        lsu_arvalid;
    logic        lsu_arready;
    logic [31:0] lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_rvalid;
    logic        lsu_rready;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;

    int checks = 0;
    int errors = 0;

    // Model: owner of the last completed read (1 = LSU after reset).
    bit m_last = 1'b1;

    ysyx_25040129_rd_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, 32'({s_arvalid, s_rready, ifu_arready, lsu_arready, ifu_rvalid, lsu_rvalid}), 32'd0);
    endtask

    // One complete read. Starts in an IDLE cycle (1ns after the edge), ends in
    // the IDLE cycle that follows the R handshake. obs_lsu reports whether the
    // DUT put the LSU address on the slave port.
    task automatic xact(input bit ri, input bit rl, input logic [31:0] ai, input logic [31:0] al,
                        input int arw, input int rw, input logic [31:0] d, input logic [1:0] resp,
                        output bit obs_lsu);
        bit exp_lsu;
        bit orr;
        bit vld;
        int v0;
        exp_lsu = (ri && rl) ? !m_last : rl;
        ifu_arvalid = ri;
        lsu_arvalid = rl;
        ifu_araddr  = ai;
        lsu_araddr  = al;
        s_arready   = 1'b0;
        s_rvalid    = 1'b0;
        #1;
        chk_quiet("idle_quiet");
        tick();
        obs_lsu = (s_araddr === al);
        for (int k = 0; k <= arw; k++) begin
            s_arready = (k == arw);
            #1;
            chk("ar_valid", 32'(s_arvalid), 32'd1);
            chk("ar_addr", s_araddr, exp_lsu ? al : ai);
            chk("ar_ready", 32'({ifu_arready, lsu_arready}),
                exp_lsu ? 32'({1'b0, (k == arw)}) : 32'({(k == arw), 1'b0}));
            chk("ar_r_quiet", 32'({ifu_rvalid, lsu_rvalid, s_rready}), 32'd0);
            tick();
        end
        s_arready = 1'b0;
        if (exp_lsu) lsu_arvalid = 1'b0;
        else         ifu_arvalid = 1'b0;
        v0 = int'($urandom_range(0, rw));
        for (int k = 0; k <= rw; k++) begin
            vld = (k >= v0);
            if (!vld) begin
                orr     = 1'($urandom_range(0, 1));
                s_rdata = $urandom;
                s_rresp = 2'($urandom_range(0, 3));
            end else begin
                orr     = (k == rw);
                s_rdata = d;
                s_rresp = resp;
            end
            s_rvalid = vld;
            if (exp_lsu) begin
                lsu_rready = orr;
                ifu_rready = 1'($urandom_range(0, 1));
            end else begin
                ifu_rready = orr;
                lsu_rready = 1'($urandom_range(0, 1));
            end
            #1;
            chk("r_s_rready", 32'(s_rready), 32'(orr));
            chk("r_own_rvalid", 32'(exp_lsu ? lsu_rvalid : ifu_rvalid), 32'(vld));
            chk("r_other_rvalid", 32'(exp_lsu ? ifu_rvalid : lsu_rvalid), 32'd0);
            chk("r_ar_quiet", 32'({s_arvalid, ifu_arready, lsu_arready}), 32'd0);
            chk("r_ifu_rdata", ifu_rdata, s_rdata);
            chk("r_lsu_rdata", lsu_rdata, s_rdata);
            chk("r_resp", 32'({ifu_rresp, lsu_rresp}), 32'({s_rresp, s_rresp}));
            if (k == rw) begin
                chk("r_final_data", exp_lsu ? lsu_rdata : ifu_rdata, d);
                chk("r_final_resp", 32'(exp_lsu ? lsu_rresp : ifu_rresp), 32'(resp));
            end
            tick();
        end
        s_rvalid   = 1'b0;
        ifu_rready = 1'b1;
        lsu_rready = 1'b1;
        m_last     = exp_lsu;
    endtask

    // Drive an LSU-only read through its address handshake into R.
    task automatic lsu_into_r(input logic [31:0] addr);
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b1;
        lsu_araddr  = addr;
        s_arready   = 1'b0;
        s_rvalid    = 1'b0;
        lsu_rready  = 1'b1;
        #1;
        chk_quiet("hang_idle");
        tick();
        s_arready = 1'b1;
        #1;
        chk("hang_ar", 32'({s_arvalid, lsu_arready}), 32'b11);
        chk("hang_addr", s_araddr, addr);
        tick();
        s_arready   = 1'b0;
        lsu_arvalid = 1'b0;
    endtask

    bit obs;

    initial begin
        rst = 1'b1;
        ifu_araddr = '0; ifu_arvalid = 1'b0; ifu_rready = 1'b1;
        lsu_araddr = '0; lsu_arvalid = 1'b0; lsu_rready = 1'b1;
        s_arready = 1'b0; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b0;

        // Reset state
        tick();
        tick();
        chk_quiet("reset_quiet");
        rst = 1'b0;

        // First tie after reset: IFU first, then LSU
        xact(1'b1, 1'b1, 32'h3000_0000, 32'h8000_0100, 0, 1, 32'h1111_2222, 2'b00, obs);
        chk("tie_first_ifu", 32'(obs), 32'd0);
        xact(1'b0, 1'b1, 32'h3000_0000, 32'h8000_0100, 0, 1, 32'h3333_4444, 2'b00, obs);
        chk("tie_then_lsu", 32'(obs), 32'd1);

        // Single IFU read, rvalid two cycles after R entry
        xact(1'b1, 1'b0, 32'h3000_0000, 32'h0, 0, 2, 32'h0000_0413, 2'b00, obs);
        chk("single_ifu", 32'(obs), 32'd0);

        // Address backpressure on an LSU read
        xact(1'b0, 1'b1, 32'h0, 32'h8000_0200, 5, 0, 32'hCAFE_F00D, 2'b00, obs);
        chk("bp_lsu", 32'(obs), 32'd1);

        // Sustained contention: IFU, LSU, IFU, LSU, IFU, LSU
        for (int k = 0; k < 6; k++) begin
            xact(1'b1, 1'b1, 32'h3000_0000 + 32'(k * 4), 32'h8000_0000 + 32'(k * 4),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom, 2'b00, obs);
            chk("cont_order", 32'(obs), 32'(k % 2));
        end

        // Randomized traffic
        for (int k = 0; k < 24; k++) begin
            bit ri;
            bit rl;
            ri = 1'($urandom_range(0, 1));
            rl = ri ? 1'($urandom_range(0, 1)) : 1'b1;
            xact(ri, rl, $urandom & 32'hFFFF_FFFC, ($urandom & 32'hFFFF_FFFC) | 32'h1,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                 2'($urandom_range(0, 3)), obs);
        end
        #1;
        chk_quiet("post_random_idle");

        // Slave hang
        lsu_into_r(32'h8000_0300);
`ifdef RD_ARB_TIMEOUT_EN
        for (int k = 0; k < 8; k++) begin
            s_rdata = $urandom;
            #1;
            chk("hang_wait_rvalid", 32'({lsu_rvalid, ifu_rvalid}), 32'd0);
            chk("hang_wait_rready", 32'(s_rready), 32'd1);
            tick();
        end
        lsu_rready = 1'b0;
        #1;
        chk("err_rvalid", 32'({lsu_rvalid, ifu_rvalid}), 32'b10);
        chk("err_resp", 32'(lsu_rresp), 32'd2);
        chk("err_data", lsu_rdata, 32'd0);
        chk("err_slave_quiet", 32'({s_arvalid, s_rready}), 32'd0);
        tick();
        chk("err_hold", 32'(lsu_rvalid), 32'd1);
        lsu_rready = 1'b1;
        tick();
        m_last = 1'b1;
        chk_quiet("err_exit_idle");
        // Back into R for the reset check
        lsu_into_r(32'h8000_0400);
        for (int k = 0; k < 3; k++) tick();
`else
        for (int k = 0; k < 100; k++) begin
            s_rdata = $urandom;
            #1;
            chk("hang_rvalid", 32'({lsu_rvalid, ifu_rvalid}), 32'd0);
            tick();
        end
`endif

        // Reset while in R
        chk("pre_reset_in_r", 32'(s_rready), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_last = 1'b1;
        chk_quiet("reset_mid_r_quiet");
        tick();
        xact(1'b1, 1'b1, 32'h3000_0040, 32'h8000_0140, 0, 0, 32'h5A5A_A5A5, 2'b00, obs);
        chk("tie_after_reset", 32'(obs), 32'd0);
        #1;
        chk_quiet("final_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
